seq_stim_src: RTL and testbench

Upstream stimulus source for the gate-level mixed-net stage. It produces the 2-bit select bus and the 1-bit flag that the consumer stage takes on its `[3:2]` select input and its single-bit flag input. Values come from a seeded 16-bit Galois LFSR, which makes the stream reproducible from a seed. Output is emitted in bursts of programmable length under a valid/ready handshake, with start/stop control and completion signalling.

---
 rtl/seq_stim_pkg.sv | 19 +
 rtl/seq_stim_lfsr.sv | 23 ++
 rtl/seq_stim_src.sv | 116 +++++++++++
 tb/tb_seq_stim_src.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_stim_pkg.sv
// Shared types and constants for the seq_stim_src stimulus source and its LFSR.
package seq_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int                SIG_W     = 8;

  // Right-shifting Galois step; the taps are folded in when bit 0 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/seq_stim_lfsr.sv
// 16-bit Galois LFSR with a synchronous load and an advance enable; load wins.
module seq_stim_lfsr
  import seq_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/seq_stim_src.sv
// Burst stimulus source: seeded LFSR beats under valid/ready with start/stop/done control.
// Optional running signature is built only when SEQ_STIM_SRC_SIG_EN is defined.
module seq_stim_src
  import seq_stim_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          BURST_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [1:0]       sel_o,
  output logic             flag_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       beat_cnt_o,
  output logic [SIG_W-1:0] sig_o,
  output seq_state_e       state_o
);

  // A zero seed would lock the LFSR at zero, so it is promoted to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
  localparam logic [7:0]        LAST_CNT = 8'(BURST_LEN - 1);

  seq_state_e        state;
  logic [LFSR_W-1:0] lfsr;
  logic              take_start;
  logic              accept;

  // Handshake: a beat transfers on a rising edge where valid_o && ready_i;
  // valid_o never depends on ready_i, and an abort (stop_i) cancels the transfer.
  assign take_start = (state == IDLE) && start_i;
  assign accept     = valid_o && ready_i && !stop_i;

  seq_stim_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (take_start),
    .advance (accept),
    .seed    (SEED_EFF),
    .state   (lfsr)
  );

  assign sel_o   = lfsr[1:0];
  assign flag_o  = ^lfsr;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      beat_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= RUN;
            valid_o    <= 1'b1;
            busy_o     <= 1'b1;
            beat_cnt_o <= '0;
          end
        end
        RUN: begin
          if (stop_i) begin
            state   <= DONE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else if (accept) begin
            beat_cnt_o <= beat_cnt_o + 8'd1;
            if (beat_cnt_o == LAST_CNT) begin
              state   <= DONE;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_STIM_SRC_SIG_EN
  logic [SIG_W-1:0] sig;

  // Rotate-left then fold in the beat being accepted (pre-advance LFSR view).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (take_start) begin
      sig <= '0;
    end else if (accept) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ {{(SIG_W-3){1'b0}}, flag_o, sel_o};
    end
  end

  assign sig_o = sig;
`else
  assign sig_o = '0;
`endif

endmodule

// File: tb/tb_seq_stim_src.sv
// Directed bench for seq_stim_src: two instances (seed 0/len 8, seed 1/len 2) checked against a burst model.
module tb_seq_stim_src;
  import seq_stim_pkg::*;

  localparam logic [15:0] SEED_A = 16'h0000;
  localparam int          BL_A   = 8;
  localparam logic [15:0] SEED_B = 16'h0001;
  localparam int          BL_B   = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic stop  = 1'b0;
  logic ready = 1'b0;

  logic       valid [2];
  logic [1:0] sel   [2];
  logic       flag  [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] cnt   [2];
  logic [7:0] sig   [2];
  seq_state_e state [2];

  seq_stim_src #(.SEED(SEED_A), .BURST_LEN(BL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .ready_i(ready),
    .valid_o(valid[0]), .sel_o(sel[0]), .flag_o(flag[0]), .busy_o(busy[0]),
    .done_o(done[0]), .beat_cnt_o(cnt[0]), .sig_o(sig[0]), .state_o(state[0])
  );

  seq_stim_src #(.SEED(SEED_B), .BURST_LEN(BL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .ready_i(ready),
    .valid_o(valid[1]), .sel_o(sel[1]), .flag_o(flag[1]), .busy_o(busy[1]),
    .done_o(done[1]), .beat_cnt_o(cnt[1]), .sig_o(sig[1]), .state_o(state[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  // model: precomputed LFSR stream per instance plus burst-level bookkeeping
  logic [15:0] seq [2][256];
  bit          m_run    [2] = '{0, 0};
  bit          m_done   [2] = '{0, 0};
  bit          m_loaded [2] = '{0, 0};
  int          m_cnt    [2] = '{0, 0};
  logic [7:0]  m_sig    [2] = '{8'h00, 8'h00};
  int          m_bl     [2] = '{BL_A, BL_B};

  initial begin
    logic [15:0] s;
    logic [15:0] seeds [2];
    seeds[0] = SEED_A;
    seeds[1] = SEED_B;
    for (int i = 0; i < 2; i++) begin
      s = (seeds[i] == 16'h0) ? 16'h0001 : seeds[i];
      for (int k = 0; k < 256; k++) begin
        seq[i][k] = s;
        s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_done[i] = 0; m_loaded[i] = 0; m_cnt[i] = 0; m_sig[i] = 8'h00;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_run[i]) begin
        if (stop) begin
          m_run[i] = 0; m_done[i] = 1;
        end else if (ready) begin
          m_sig[i] = {m_sig[i][6:0], m_sig[i][7]}
                     ^ {5'b0, ^seq[i][m_cnt[i]], seq[i][m_cnt[i]][1:0]};
          m_cnt[i]++;
          if (m_cnt[i] == m_bl[i]) begin
            m_run[i] = 0; m_done[i] = 1;
          end
        end
      end else if (start) begin
        m_run[i] = 1; m_loaded[i] = 1; m_cnt[i] = 0; m_sig[i] = 8'h00;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] cur;
        cur = m_loaded[i] ? seq[i][m_cnt[i]] : 16'h0000;
        check("valid", i, 16'(valid[i]), 16'(m_run[i]));
        check("busy",  i, 16'(busy[i]),  16'(m_run[i]));
        check("done",  i, 16'(done[i]),  16'(m_done[i]));
        check("cnt",   i, 16'(cnt[i]),   16'(m_cnt[i]));
        check("sel",   i, 16'(sel[i]),   16'(cur[1:0]));
        check("flag",  i, 16'(flag[i]),  16'(^cur));
        check("state", i, 16'(state[i]), m_run[i] ? 16'(RUN) : (m_done[i] ? 16'(DONE) : 16'(IDLE)));
`ifdef SEQ_STIM_SRC_SIG_EN
        check("sig",   i, 16'(sig[i]),   16'(m_sig[i]));
`else
        check("sig",   i, 16'(sig[i]),   16'h0000);
`endif
      end
    end
  end

  task automatic wait_done_a();
    int n = 0;
    while (!done[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 0, 16'(done[0]), 16'h0001);
  endtask

  task automatic idle_gap();
    repeat (4) @(negedge clk);
  endtask

  // driver
  initial begin
    int beats;
    int n;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", i, 16'(valid[i]), 16'h0);
      check("rst_cnt",   i, 16'(cnt[i]),   16'h0);
      check("rst_sel",   i, 16'(sel[i]),   16'h0);
      check("rst_done",  i, 16'(done[i]),  16'h0);
    end
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);

    // seed 1 (b) and zero seed (a): two beats then done on b
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_b1_sel", 1, 16'(sel[1]), 16'h1);
    check("t1_b1_flag", 1, 16'(flag[1]), 16'h1);
    check("t5_a1_sel", 0, 16'(sel[0]), 16'h1);
    check("t5_a1_flag", 0, 16'(flag[0]), 16'h1);
    @(negedge clk);
    check("t1_b2_sel", 1, 16'(sel[1]), 16'h0);
    check("t1_b2_flag", 1, 16'(flag[1]), 16'h0);
`ifdef SEQ_STIM_SRC_SIG_EN
    check("t6_sig1", 1, 16'(sig[1]), 16'h05);
`else
    check("t6_sig1", 1, 16'(sig[1]), 16'h00);
`endif
    @(negedge clk);
    check("t1_done", 1, 16'(done[1]), 16'h1);
    check("t1_valid", 1, 16'(valid[1]), 16'h0);
    check("t1_cnt", 1, 16'(cnt[1]), 16'h2);
`ifdef SEQ_STIM_SRC_SIG_EN
    check("t6_sig2", 1, 16'(sig[1]), 16'h0A);
`else
    check("t6_sig2", 1, 16'(sig[1]), 16'h00);
`endif
    @(negedge clk);
    check("t1_done_pulse", 1, 16'(done[1]), 16'h0);
    wait_done_a();
    check("t1_a_cnt", 0, 16'(cnt[0]), 16'h8);
    idle_gap();

    // backpressure: stall after the first accepted beat
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_cnt", 0, 16'(cnt[0]), 16'h1);
      check("t2_stall_sel", 0, 16'(sel[0]), 16'h0);
      check("t2_stall_valid", 0, 16'(valid[0]), 16'h1);
    end
    ready = 1'b1;
    wait_done_a();
    check("t2_cnt", 0, 16'(cnt[0]), 16'h8);
    idle_gap();

    // abort on beat 3 together with ready
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_done", 0, 16'(done[0]), 16'h1);
    check("t3_valid", 0, 16'(valid[0]), 16'h0);
    check("t3_cnt", 0, 16'(cnt[0]), 16'h2);
    idle_gap();

    // reset mid-burst, then replay from the seed
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_valid", 0, 16'(valid[0]), 16'h0);
    check("t4_busy", 0, 16'(busy[0]), 16'h0);
    check("t4_done", 0, 16'(done[0]), 16'h0);
    check("t4_cnt", 0, 16'(cnt[0]), 16'h0);
    check("t4_sel", 0, 16'(sel[0]), 16'h0);
    check("t4_flag", 0, 16'(flag[0]), 16'h0);
    check("t4_sig", 0, 16'(sig[0]), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_no_done", 0, 16'(done[0]), 16'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_replay_sel", 0, 16'(sel[0]), 16'h1);
    check("t4_replay_flag", 0, 16'(flag[0]), 16'h1);
    wait_done_a();
    idle_gap();

    // start+stop together in IDLE, then a start pulse in RUN that must be ignored
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_startstop_valid", 0, 16'(valid[0]), 16'h1);
    beats = 0;
    n = 0;
    do begin
      if (valid[0]) beats++;
      start = (n == 2);
      @(negedge clk);
      n++;
    end while (!done[0] && n < 40);
    start = 1'b0;
    check("t5_beats", 0, 16'(beats), 16'h8);
    check("t5_cnt", 0, 16'(cnt[0]), 16'h8);
    idle_gap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
